// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache-to-main-memory arbiter: line geometry
// defaults, FSM state encoding and a one-hot helper.
package cache_mem_arbiter_pkg;

  localparam int CACHE_ADDR_LEN  = 5;
  localparam int CACHE_MEMORY_DW = 256;
  localparam int CACHE_MEMORY_MW = CACHE_MEMORY_DW / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  function automatic logic [1:0] onehot_of(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_mem_arb_pick.sv
// Combinational 2-way pick: a lone requester wins outright, on contention
// the requester named by rr_ptr wins. Output is one-hot, or 00 if no request.
module cache_mem_arb_pick
  import cache_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = onehot_of(rr_ptr);
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main_memory refill/writeback port between two cache masters,
// holding the grant from command through response. Define CACHE_MEM_ARB_RR_EN
// for round-robin contention handling; otherwise m0 has fixed priority.
//
//  state    | meaning
//  ARB_IDLE | no owner; arbitrate among pending cmd_valid
//  ARB_CMD  | owner's command routed to memory, waiting for cmd handshake
//  ARB_RSP  | waiting for the single response, routed back to the owner
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_LEN  = CACHE_ADDR_LEN,
  parameter int MEMORY_DW = CACHE_MEMORY_DW,
  parameter int MEMORY_MW = CACHE_MEMORY_MW
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 m0_cmd_valid,
  output logic                 m0_cmd_ready,
  input  logic                 m0_cmd_read,
  input  logic [ADDR_LEN-1:0]  m0_cmd_addr,
  input  logic [MEMORY_DW-1:0] m0_cmd_wdata,
  input  logic [MEMORY_MW-1:0] m0_cmd_wmask,
  output logic                 m0_rsp_valid,
  input  logic                 m0_rsp_ready,
  output logic [MEMORY_DW-1:0] m0_rsp_rdata,

  input  logic                 m1_cmd_valid,
  output logic                 m1_cmd_ready,
  input  logic                 m1_cmd_read,
  input  logic [ADDR_LEN-1:0]  m1_cmd_addr,
  input  logic [MEMORY_DW-1:0] m1_cmd_wdata,
  input  logic [MEMORY_MW-1:0] m1_cmd_wmask,
  output logic                 m1_rsp_valid,
  input  logic                 m1_rsp_ready,
  output logic [MEMORY_DW-1:0] m1_rsp_rdata,

  output logic                 memory_cmd_valid,
  input  logic                 memory_cmd_ready,
  output logic                 memory_cmd_read,
  output logic [ADDR_LEN-1:0]  memory_cmd_addr,
  output logic [MEMORY_DW-1:0] memory_cmd_wdata,
  output logic [MEMORY_MW-1:0] memory_cmd_wmask,
  input  logic                 memory_rsp_valid,
  output logic                 memory_rsp_ready,
  input  logic [MEMORY_DW-1:0] memory_rsp_rdata,

  output logic                 arb_busy,
  output logic [1:0]           arb_grant
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       rr_ptr;
  logic [1:0] pick;
  logic       sel;
  logic       in_cmd, in_rsp;
  logic       g_cmd_valid, g_rsp_ready;

`ifdef CACHE_MEM_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  cache_mem_arb_pick u_pick (
    .req    ({m1_cmd_valid, m0_cmd_valid}),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  // grant_q is 00 in IDLE, so sel defaults to m0 there; every valid/ready is
  // additionally qualified by state so IDLE drives nothing.
  assign sel    = grant_q[1];
  assign in_cmd = (state_q == ARB_CMD);
  assign in_rsp = (state_q == ARB_RSP);

  always_comb begin
    g_cmd_valid      = sel ? m1_cmd_valid : m0_cmd_valid;
    g_rsp_ready      = sel ? m1_rsp_ready : m0_rsp_ready;
    memory_cmd_read  = sel ? m1_cmd_read  : m0_cmd_read;
    memory_cmd_addr  = sel ? m1_cmd_addr  : m0_cmd_addr;
    memory_cmd_wdata = sel ? m1_cmd_wdata : m0_cmd_wdata;
    memory_cmd_wmask = sel ? m1_cmd_wmask : m0_cmd_wmask;

    memory_cmd_valid = in_cmd & g_cmd_valid;
    m0_cmd_ready     = in_cmd & ~sel & memory_cmd_ready;
    m1_cmd_ready     = in_cmd &  sel & memory_cmd_ready;

    memory_rsp_ready = in_rsp & g_rsp_ready;
    m0_rsp_valid     = in_rsp & ~sel & memory_rsp_valid;
    m1_rsp_valid     = in_rsp &  sel & memory_rsp_valid;
    m0_rsp_rdata     = memory_rsp_rdata;
    m1_rsp_rdata     = memory_rsp_rdata;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
`ifdef CACHE_MEM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|pick) begin
          state_d = ARB_CMD;
          grant_d = pick;
          busy_d  = 1'b1;
        end
      end
      ARB_CMD: begin
        // Owner withdrew before the handshake: release without touching rr_ptr.
        if (!g_cmd_valid) begin
          state_d = ARB_IDLE;
          grant_d = 2'b00;
          busy_d  = 1'b0;
        end else if (memory_cmd_ready) begin
          state_d = ARB_RSP;
        end
      end
      ARB_RSP: begin
        if (memory_rsp_valid && g_rsp_ready) begin
          state_d = ARB_IDLE;
          grant_d = 2'b00;
          busy_d  = 1'b0;
`ifdef CACHE_MEM_ARB_RR_EN
          rr_ptr_d = ~sel;
`endif
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= 2'b00;
      busy_q   <= 1'b0;
`ifdef CACHE_MEM_ARB_RR_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
`ifdef CACHE_MEM_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign arb_busy  = busy_q;
  assign arb_grant = grant_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 256;
  localparam int MW = 32;
`ifdef CACHE_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    cv, rd, rr;
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic [MW-1:0] wm [2];
  logic          mem_cmd_ready, mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;

  wire           m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid;
  wire [DW-1:0]  m0_rsp_rdata, m1_rsp_rdata;
  wire           memory_cmd_valid, memory_cmd_read, memory_rsp_ready;
  wire [AW-1:0]  memory_cmd_addr;
  wire [DW-1:0]  memory_cmd_wdata;
  wire [MW-1:0]  memory_cmd_wmask;
  wire           arb_busy;
  wire [1:0]     arb_grant;

  int n_cmp = 0;
  int n_err = 0;

  cache_mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_cmd_valid     (cv[0]),
    .m0_cmd_ready     (m0_cmd_ready),
    .m0_cmd_read      (rd[0]),
    .m0_cmd_addr      (ad[0]),
    .m0_cmd_wdata     (wd[0]),
    .m0_cmd_wmask     (wm[0]),
    .m0_rsp_valid     (m0_rsp_valid),
    .m0_rsp_ready     (rr[0]),
    .m0_rsp_rdata     (m0_rsp_rdata),
    .m1_cmd_valid     (cv[1]),
    .m1_cmd_ready     (m1_cmd_ready),
    .m1_cmd_read      (rd[1]),
    .m1_cmd_addr      (ad[1]),
    .m1_cmd_wdata     (wd[1]),
    .m1_cmd_wmask     (wm[1]),
    .m1_rsp_valid     (m1_rsp_valid),
    .m1_rsp_ready     (rr[1]),
    .m1_rsp_rdata     (m1_rsp_rdata),
    .memory_cmd_valid (memory_cmd_valid),
    .memory_cmd_ready (mem_cmd_ready),
    .memory_cmd_read  (memory_cmd_read),
    .memory_cmd_addr  (memory_cmd_addr),
    .memory_cmd_wdata (memory_cmd_wdata),
    .memory_cmd_wmask (memory_cmd_wmask),
    .memory_rsp_valid (mem_rsp_valid),
    .memory_rsp_ready (memory_rsp_ready),
    .memory_rsp_rdata (mem_rsp_rdata),
    .arb_busy         (arb_busy),
    .arb_grant        (arb_grant)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, whether its command has
  // already been accepted, and who is preferred on the next tie.
  int owner = -1;
  bit m_rsp = 1'b0;
  int pref = 0;
  int served = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= -1;
      m_rsp <= 1'b0;
      pref  <= 0;
    end else if (owner < 0) begin
      if (cv == 2'b11)  owner <= RR ? pref : 0;
      else if (cv[0])   owner <= 0;
      else if (cv[1])   owner <= 1;
      m_rsp <= 1'b0;
    end else if (!m_rsp) begin
      if (!cv[owner])         owner <= -1;
      else if (mem_cmd_ready) m_rsp <= 1'b1;
    end else if (mem_rsp_valid && rr[owner]) begin
      owner  <= -1;
      m_rsp  <= 1'b0;
      pref   <= 1 - owner;
      served <= served + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [1:0] eg, ecr, erv;
    logic       emv, err;
    eg  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    ecr = 2'b00;
    erv = 2'b00;
    emv = 1'b0;
    err = 1'b0;
    if (owner >= 0 && !m_rsp) begin
      emv = cv[owner];
      ecr = eg & {2{mem_cmd_ready}};
    end
    if (owner >= 0 && m_rsp) begin
      erv = eg & {2{mem_rsp_valid}};
      err = rr[owner];
    end
    chk("m_busy", arb_busy, owner >= 0);
    chk("m_grant", arb_grant, eg);
    chk("m_mem_cmd_valid", memory_cmd_valid, emv);
    chk("m_cmd_ready", {m1_cmd_ready, m0_cmd_ready}, ecr);
    chk("m_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, erv);
    chk("m_mem_rsp_ready", memory_rsp_ready, err);
    chk("m_rdata", {m1_rsp_rdata ^ mem_rsp_rdata} | {m0_rsp_rdata ^ mem_rsp_rdata}, '0);
    if (owner >= 0 && !m_rsp) begin
      chk("m_cmd_read", memory_cmd_read, rd[owner]);
      chk("m_cmd_addr", memory_cmd_addr, ad[owner]);
      chk("m_cmd_wdata", memory_cmd_wdata, wd[owner]);
      chk("m_cmd_wmask", memory_cmd_wmask, wm[owner]);
    end
  end

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic clear_inputs();
    cv = '0; rd = '0; rr = '0;
    for (int k = 0; k < 2; k++) begin
      ad[k] = '0; wd[k] = '0; wm[k] = '0;
    end
    mem_cmd_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; reset asserts and releases well inside the cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] pat;
    clear_inputs();
    // Reset state with every input pulling the other way
    @(posedge clk);
    #1;
    cv = 2'b11; rr = 2'b11; mem_cmd_ready = 1'b1; mem_rsp_valid = 1'b1;
    #1;
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_grant", arb_grant, 2'b00);
    chk("rst_mem_cmd_valid", memory_cmd_valid, 1'b0);
    chk("rst_mem_rsp_ready", memory_rsp_ready, 1'b0);
    chk("rst_cmd_ready", {m1_cmd_ready, m0_cmd_ready}, 2'b00);
    chk("rst_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    step();
    do_reset();

    // 1: single m0 read
    step();
    cv[0] = 1'b1; rd[0] = 1'b1; ad[0] = 5'h03; mem_cmd_ready = 1'b1;
    #3;
    chk("t1_arb_grant", arb_grant, 2'b00);
    step();
    #3;
    chk("t1_grant", arb_grant, 2'b01);
    chk("t1_addr", memory_cmd_addr, 5'h03);
    chk("t1_read", memory_cmd_read, 1'b1);
    chk("t1_m0_cmd_ready", m0_cmd_ready, 1'b1);
    step();
    cv[0] = 1'b0; rr[0] = 1'b1; pat = {8{32'hA5A5_0F0F}}; mem_rsp_rdata = pat;
    #2;
    chk("t1_rsp_valid_lo", m0_rsp_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    #1;
    chk("t1_rsp_valid_hi", m0_rsp_valid, 1'b1);
    chk("t1_rdata", m0_rsp_rdata, pat);
    chk("t1_mem_rsp_ready", memory_rsp_ready, 1'b1);
    step();
    clear_inputs();
    #3;
    chk("t1_idle_busy", arb_busy, 1'b0);
    do_reset();

    // 2/3: contention, m0 re-requests right after being served
    step();
    cv = 2'b11; rd = 2'b11; ad[0] = 5'h01; ad[1] = 5'h02; mem_cmd_ready = 1'b1;
    #3;
    chk("t2_arb_grant", arb_grant, 2'b00);
    step();
    #3;
    chk("t2_first_grant", arb_grant, 2'b01);
    chk("t2_first_addr", memory_cmd_addr, 5'h01);
    step();
    cv[0] = 1'b0; mem_rsp_valid = 1'b1; rr = 2'b11;
    #3;
    chk("t2_rsp_grant", arb_grant, 2'b01);
    step();
    cv[0] = 1'b1;
    #3;
    chk("t2_gap_grant", arb_grant, 2'b00);
    step();
    #3;
    chk("t2_second_grant", arb_grant, RR ? 2'b10 : 2'b01);
    chk("t2_second_addr", memory_cmd_addr, RR ? 5'h02 : 5'h01);
    do_reset();

    // 4/5: m1 write stalled by memory, then response stalled by m1
    step();
    cv[1] = 1'b1; rd[1] = 1'b0; ad[1] = 5'h1C; wm[1] = 32'hFFFF_0000;
    pat = rand256(); wd[1] = pat;
    step();
    cv[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("t4_grant", arb_grant, 2'b10);
      chk("t4_wmask", memory_cmd_wmask, 32'hFFFF_0000);
      chk("t4_addr", memory_cmd_addr, 5'h1C);
      chk("t4_wdata", memory_cmd_wdata, pat);
      chk("t4_read", memory_cmd_read, 1'b0);
      chk("t4_cmd_ready", {m1_cmd_ready, m0_cmd_ready}, 2'b00);
      step();
    end
    mem_cmd_ready = 1'b1;
    #3;
    chk("t4_cmd_ready_hs", {m1_cmd_ready, m0_cmd_ready}, 2'b10);
    step();
    cv[1] = 1'b0; mem_rsp_valid = 1'b1; rr = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("t5_mem_rsp_ready", memory_rsp_ready, 1'b0);
      chk("t5_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b10);
      chk("t5_hold_grant", arb_grant, 2'b10);
      step();
    end
    rr[1] = 1'b1;
    #3;
    chk("t5_mem_rsp_ready_hi", memory_rsp_ready, 1'b1);
    step();
    #3;
    chk("t5_idle_grant", arb_grant, 2'b00);
    step();
    #3;
    chk("t5_m0_next", arb_grant, 2'b01);
    do_reset();

    // 6: asynchronous reset while in RSP
    step();
    cv[0] = 1'b1; rd[0] = 1'b1; mem_cmd_ready = 1'b1;
    step();
    step();
    cv = 2'b00; mem_rsp_valid = 1'b1; rr = 2'b11;
    #1;
    chk("t6_pre_busy", arb_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", arb_busy, 1'b0);
    chk("t6_grant", arb_grant, 2'b00);
    chk("t6_mem_rsp_ready", memory_rsp_ready, 1'b0);
    chk("t6_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b0; rr = 2'b00; cv[0] = 1'b1;
    step();
    #3;
    chk("t6_regrant", arb_grant, 2'b01);
    do_reset();

    // Randomized traffic, checked every cycle by the model comparator
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (cv[k]) cv[k] = ($urandom_range(0, 9) != 0);
        else       cv[k] = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) begin
          rd[k] = $urandom_range(0, 1);
          ad[k] = AW'($urandom());
          wd[k] = rand256();
          wm[k] = $urandom();
        end
        rr[k] = ($urandom_range(0, 9) < 6);
      end
      mem_cmd_ready = $urandom_range(0, 1);
      mem_rsp_valid = $urandom_range(0, 1);
      mem_rsp_rdata = rand256();
    end
    step();
    chk("served_enough", served > 50, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
